// File: rtl/apb_mem_slave_param_pkg.sv
// Shared types and helpers for the APB memory slave.
// The optional byte-strobe build is selected with the APB_STRB_EN macro.
package apb_slave_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_t;

  localparam int WAIT_W  = 4;
  localparam int RANGE_W = 32;

  // Out-of-range flag; addresses never wrap, so compare at full width.
  function automatic logic addr_out_of_range(input logic [RANGE_W-1:0] addr,
                                             input logic [RANGE_W-1:0] depth);
    return (addr >= depth);
  endfunction

endpackage

// File: rtl/apb_mem_slave_param_if.sv
// APB3 bus bundle between a master and the memory slave.
// The pstrb lane-enable signal exists only when APB_STRB_EN is defined.
interface apb_mem_slave_param_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
`ifdef APB_STRB_EN
  logic [DATA_W/8-1:0] pstrb;
`endif
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport master (
`ifdef APB_STRB_EN
    output pstrb,
`endif
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
`ifdef APB_STRB_EN
    input  pstrb,
`endif
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_mem_slave_param_wait_ctr.sv
// Wait-state counter: loads at setup, counts down to zero and holds there.
module apb_wait_ctr #(
  parameter int WAIT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  output logic              zero
);

  logic [WAIT_W-1:0] count;

  // Load wins over decrement; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {WAIT_W{1'b0}};
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != {WAIT_W{1'b0}})) begin
      count <= count - {{(WAIT_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign zero = (count == {WAIT_W{1'b0}});

endmodule

// File: rtl/apb_mem_slave_param.sv
// Parametrised APB3 word-addressed memory slave with wait states and pslverr.
// Define APB_STRB_EN to add per-byte write strobes (pstrb).
module apb_mem_slave_param
  import apb_slave_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  pclk,
  input  logic                  preset,
  apb_mem_slave_param_if.slave  apb
);

  localparam int LANES = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_state_t        state;
  apb_state_t        state_nxt;
  logic [IDX_W-1:0]  idx_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic [DATA_W-1:0] prdata_q;
  logic [LANES-1:0]  lane_en;
  logic              ctr_zero;
  logic              setup;
  logic              done;
  logic              abort;
  logic              setup_err;
  logic              pready_int;
  logic [DATA_W-1:0] mem [DEPTH];

  assign setup      = (state == IDLE) && apb.psel && !apb.penable;
  assign pready_int = (state == ACCESS) && ctr_zero;
  assign done       = (state == ACCESS) && apb.psel && apb.penable && pready_int;
  assign abort      = (state == ACCESS) && !apb.psel;

`ifdef APB_STRB_EN
  logic [LANES-1:0] strb_q;

  // A read carrying any strobe bit is a protocol error.
  assign setup_err = addr_out_of_range(RANGE_W'(apb.paddr), RANGE_W'(DEPTH)) |
                     (!apb.pwrite && (apb.pstrb != {LANES{1'b0}}));
  assign lane_en   = strb_q;

  // Strobes are captured with the rest of the setup phase.
  always_ff @(posedge pclk) begin
    if (preset) begin
      strb_q <= {LANES{1'b0}};
    end else if (setup) begin
      strb_q <= apb.pstrb;
    end else begin
      strb_q <= strb_q;
    end
  end
`else
  assign setup_err = addr_out_of_range(RANGE_W'(apb.paddr), RANGE_W'(DEPTH));
  assign lane_en   = {LANES{1'b1}};
`endif

  apb_wait_ctr #(.WAIT_W(WAIT_W)) u_wait_ctr (
    .clk      (pclk),
    .rst      (preset),
    .load     (setup),
    .load_val (WAIT_W'(WAIT_CYCLES)),
    .dec      (state == ACCESS),
    .zero     (ctr_zero)
  );

  // State register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; penable without a prior setup leaves IDLE untouched.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (setup) begin
          state_nxt = ACCESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCESS: begin
        if (done || abort) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = ACCESS;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Setup-phase capture; read data is fetched here and held until the next read.
  always_ff @(posedge pclk) begin
    if (preset) begin
      idx_q    <= {IDX_W{1'b0}};
      write_q  <= 1'b0;
      wdata_q  <= {DATA_W{1'b0}};
      err_q    <= 1'b0;
      prdata_q <= {DATA_W{1'b0}};
    end else if (setup) begin
      idx_q   <= apb.paddr[IDX_W-1:0];
      write_q <= apb.pwrite;
      wdata_q <= apb.pwdata;
      err_q   <= setup_err;
      if (!apb.pwrite) begin
        prdata_q <= setup_err ? {DATA_W{1'b0}} : mem[apb.paddr[IDX_W-1:0]];
      end else begin
        prdata_q <= prdata_q;
      end
    end else begin
      idx_q    <= idx_q;
      write_q  <= write_q;
      wdata_q  <= wdata_q;
      err_q    <= err_q;
      prdata_q <= prdata_q;
    end
  end

  // Storage: cleared by reset, written per enabled lane on an error-free completion.
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem[w] <= {DATA_W{1'b0}};
      end
    end else if (done && write_q && !err_q) begin
      for (int b = 0; b < LANES; b++) begin
        if (lane_en[b]) begin
          mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
      end
    end
  end

  assign apb.pready  = pready_int;
  assign apb.pslverr = pready_int & err_q;
  assign apb.prdata  = prdata_q;

endmodule
